// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared encodings for the data-memory arbiter: FSM state
//                codes and requester (owner) identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Requester identifiers
    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-way round-robin picker. A lone request
//                wins outright; on a tie the requester that was NOT granted
//                last wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       sel,
    output logic       valid
);

    // Select a requester; tie broken against the last winner
    always_comb begin
        valid = |req;
        sel   = OWNER_M0;
        if (req == 2'b11) begin
            sel = ~last;
        end else if (req[1]) begin
            sel = OWNER_M1;
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares a single-port synchronous RAM between two requesters
//                (m0 = cpu load/store, m1 = secondary master) with round-robin
//                arbitration and one access in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q,

    output logic          busy
);

    localparam int            CW       = $clog2(RD_LAT) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);

    logic [1:0]    state;
    logic          owner;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [CW-1:0] cnt;
    logic          last_owner;
    logic          granted_any;

    logic          last_eff;
    logic          pick_sel;
    logic          pick_valid;

    // Until the first grant after reset, act as if m1 went last so that the
    // pointer's reset value (m0) also means m0 wins the first tie.
    assign last_eff = granted_any ? last_owner : OWNER_M1;

    rr_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last_eff),
        .sel   (pick_sel),
        .valid (pick_valid)
    );

    // Arbitration FSM, request latch, round-robin pointer and latency counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            owner       <= OWNER_M0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            cnt         <= '0;
            last_owner  <= OWNER_M0;
            granted_any <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick_sel;
                        lat_we    <= (pick_sel == OWNER_M1) ? m1_we    : m0_we;
                        lat_addr  <= (pick_sel == OWNER_M1) ? m1_addr  : m0_addr;
                        lat_wdata <= (pick_sel == OWNER_M1) ? m1_wdata : m0_wdata;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    last_owner  <= owner;
                    granted_any <= 1'b1;
                    cnt         <= CNT_INIT;
                    state       <= lat_we ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-data capture into the owner's holding register on the last WAIT cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else if (state == ST_WAIT && cnt == '0) begin
            if (owner == OWNER_M1) begin
                m1_rdata <= ram_q;
            end else begin
                m0_rdata <= ram_q;
            end
        end
    end

    // RAM side is driven straight from the latch; the address stays put
    // through WAIT so the RAM sees a stable address for the whole read.
    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;
    assign ram_wren  = (state == ST_ISSUE) && lat_we;

    assign m0_gnt    = (state == ST_ISSUE) && (owner == OWNER_M0);
    assign m1_gnt    = (state == ST_ISSUE) && (owner == OWNER_M1);
    assign m0_rvalid = (state == ST_RESP)  && (owner == OWNER_M0);
    assign m1_rvalid = (state == ST_RESP)  && (owner == OWNER_M1);

    assign busy      = (state != ST_IDLE);

endmodule : dmem_arbiter
`default_nettype wire
